// File: rtl/fb_out_serializer.sv
// Ping-pong frame buffer and beat serializer behind the 8-band filter bank.
// Optional FBS_DROP_COUNT_EN enables a saturating dropped-frame counter on drop_count.
module fb_out_serializer #(
    parameter int unsigned DW         = 16,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         frame_stb,
    input  logic signed [DW-1:0]         band0,
    input  logic signed [DW-1:0]         band1,
    input  logic signed [DW-1:0]         band2,
    input  logic signed [DW-1:0]         band3,
    input  logic signed [DW-1:0]         band4,
    input  logic signed [DW-1:0]         band5,
    input  logic signed [DW-1:0]         band6,
    input  logic signed [DW-1:0]         band7,
    output logic signed [DW-1:0]         tdata,
    output logic        [2:0]            tchan,
    output logic                         tlast,
    output logic                         tvalid,
    input  logic                         tready,
    output logic                         overrun,
    output logic        [DROP_CNT_W-1:0] drop_count
);

    localparam int unsigned NCH    = 8;
    localparam int unsigned CW     = 3;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     chan_q, chan_d;
    logic              wp_q, wp_d;
    logic              rp_q, rp_d;
    logic [1:0]        full_q, full_d;
    logic [DW-1:0]     buf_q [2][NCH];
    logic [DW-1:0]     buf_d [2][NCH];
    logic [DW-1:0]     tdata_q, tdata_d;
    logic [CW-1:0]     tchan_q, tchan_d;
    logic              tlast_q, tlast_d;
    logic              tvalid_q, tvalid_d;
    logic              overrun_q, overrun_d;

    logic [DW-1:0]     band_a [NCH];
    logic              hs;
    logic              free_now;
    logic [1:0]        full_free;
    logic              capture;
    logic              drop;

    assign band_a[0] = band0;
    assign band_a[1] = band1;
    assign band_a[2] = band2;
    assign band_a[3] = band3;
    assign band_a[4] = band4;
    assign band_a[5] = band5;
    assign band_a[6] = band6;
    assign band_a[7] = band7;

    // A buffer released by this cycle's ch7 handshake is already free for a capture this cycle.
    always_comb begin
        hs        = (state_q == ST_SEND) && tready;
        free_now  = hs && (chan_q == LAST_CH);
        full_free = full_q;
        if (free_now) begin
            full_free[rp_q] = 1'b0;
        end
        capture   = frame_stb && !full_free[wp_q];
        drop      = frame_stb &&  full_free[wp_q];
    end

    always_comb begin
        buf_d     = buf_q;
        full_d    = full_free;
        wp_d      = wp_q;
        rp_d      = rp_q ^ free_now;
        state_d   = state_q;
        chan_d    = chan_q;
        overrun_d = drop;

        if (capture) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                buf_d[wp_q][i] = band_a[i];
            end
            full_d[wp_q] = 1'b1;
            wp_d         = ~wp_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_d[rp_d]) begin
                    state_d = ST_SEND;
                    chan_d  = '0;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (chan_q != LAST_CH) begin
                        chan_d = chan_q + CW'(1);
                    end else if (full_d[rp_d]) begin
                        chan_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are computed from next-cycle state so a fresh capture is visible one cycle later.
        tvalid_d = (state_d == ST_SEND);
        tdata_d  = tvalid_d ? buf_d[rp_d][chan_d] : '0;
        tchan_d  = tvalid_d ? chan_d : '0;
        tlast_d  = tvalid_d && (chan_d == LAST_CH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            chan_q    <= '0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            full_q    <= '0;
            tdata_q   <= '0;
            tchan_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            full_q    <= full_d;
            tdata_q   <= tdata_d;
            tchan_q   <= tchan_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
        end
    end

    // Buffer contents are qualified by full flags, so they need no reset.
    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

    assign tdata   = tdata_q;
    assign tchan   = tchan_q;
    assign tlast   = tlast_q;
    assign tvalid  = tvalid_q;
    assign overrun = overrun_q;

`ifdef FBS_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fb_out_serializer.sv
// Bench for fb_out_serializer: directed scenarios plus random traffic against a frame-queue model.
module tb_fb_out_serializer;

    localparam int unsigned DW  = 16;
    localparam int unsigned DCW = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  frame_stb;
    logic                  tready;
    logic [8*DW-1:0]       cur_frame;
    logic signed [DW-1:0]  tdata;
    logic [2:0]            tchan;
    logic                  tlast;
    logic                  tvalid;
    logic                  overrun;
    logic [DCW-1:0]        drop_count;

    fb_out_serializer #(.DW(DW), .DROP_CNT_W(DCW)) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_stb  (frame_stb),
        .band0      (cur_frame[0*DW +: DW]),
        .band1      (cur_frame[1*DW +: DW]),
        .band2      (cur_frame[2*DW +: DW]),
        .band3      (cur_frame[3*DW +: DW]),
        .band4      (cur_frame[4*DW +: DW]),
        .band5      (cur_frame[5*DW +: DW]),
        .band6      (cur_frame[6*DW +: DW]),
        .band7      (cur_frame[7*DW +: DW]),
        .tdata      (tdata),
        .tchan      (tchan),
        .tlast      (tlast),
        .tvalid     (tvalid),
        .tready     (tready),
        .overrun    (overrun),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    // Model: queue of frames not yet fully sent (at most two), beat index into the head frame.
    logic [8*DW-1:0] fq[$];
    int              idx;
    logic            exp_ovr;
    logic [DCW-1:0]  exp_dc;
    int              n_total;
    int              n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8*DW-1:0] rnd_frame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [8*DW-1:0] seq_frame(input int base);
        logic [8*DW-1:0] f;
        for (int c = 0; c < 8; c++) f[c*DW +: DW] = DW'(base + c);
        return f;
    endfunction

    task automatic step(input logic stb, input logic rdy, input logic rst, input logic [8*DW-1:0] fr);
        logic            hs;
        logic [8*DW-1:0] head;
        frame_stb = stb;
        tready    = rdy;
        reset     = rst;
        cur_frame = fr;
        @(posedge clock);
        if (rst) begin
            fq.delete();
            idx     = 0;
            exp_ovr = 1'b0;
            exp_dc  = '0;
        end else begin
            hs      = (fq.size() > 0) && rdy;
            exp_ovr = 1'b0;
            if (hs) begin
                if (idx == 7) begin
                    void'(fq.pop_front());
                    idx = 0;
                end else begin
                    idx++;
                end
            end
            if (stb) begin
                if (fq.size() < 2) begin
                    fq.push_back(fr);
                end else begin
                    exp_ovr = 1'b1;
`ifdef FBS_DROP_COUNT_EN
                    if (exp_dc != '1) exp_dc = exp_dc + DCW'(1);
`endif
                end
            end
        end
        #1;
        chk("tvalid", {31'b0, tvalid}, {31'b0, fq.size() > 0});
        chk("overrun", {31'b0, overrun}, {31'b0, exp_ovr});
        chk("drop_count", 32'(drop_count), 32'(exp_dc));
        if (fq.size() > 0) begin
            head = fq[0];
            chk("tdata", {16'h0, tdata}, {16'h0, head[idx*DW +: DW]});
            chk("tchan", {29'b0, tchan}, 32'(idx));
            chk("tlast", {31'b0, tlast}, {31'b0, idx == 7});
        end else if (rst) begin
            chk("rst_tdata", {16'h0, tdata}, 32'h0);
            chk("rst_tchan", {29'b0, tchan}, 32'h0);
            chk("rst_tlast", {31'b0, tlast}, 32'h0);
        end
        frame_stb = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, rnd_frame());
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        idx       = 0;
        exp_ovr   = 1'b0;
        exp_dc    = '0;
        reset     = 1'b1;
        frame_stb = 1'b0;
        tready    = 1'b1;
        cur_frame = '0;

        // Reset state
        step(1'b0, 1'b1, 1'b1, '0);
        step(1'b0, 1'b1, 1'b1, '0);

        // Single frame 1..8 with tready held high
        step(1'b1, 1'b1, 1'b0, seq_frame(1));
        idle(10, 1'b1);

        // Backpressure from the ch3 beat for five cycles
        step(1'b1, 1'b1, 1'b0, seq_frame(16'h0101));
        idle(3, 1'b1);
        idle(5, 1'b0);
        idle(8, 1'b1);

        // A and B buffered, C dropped, then back-to-back drain
        step(1'b1, 1'b0, 1'b0, rnd_frame());
        idle(9, 1'b0);
        step(1'b1, 1'b0, 1'b0, rnd_frame());
        idle(9, 1'b0);
        step(1'b1, 1'b0, 1'b0, rnd_frame());
        idle(3, 1'b0);
        idle(20, 1'b1);

        // Capture in the same cycle as A's ch7 handshake with both buffers full
        step(1'b1, 1'b0, 1'b0, rnd_frame());
        idle(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, rnd_frame());
        idle(3, 1'b0);
        idle(7, 1'b1);
        step(1'b1, 1'b1, 1'b0, rnd_frame());
        idle(20, 1'b1);

        // Reset during the ch5 beat, then a fresh frame
        step(1'b1, 1'b1, 1'b0, rnd_frame());
        step(1'b1, 1'b0, 1'b0, rnd_frame());
        idle(5, 1'b1);
        step(1'b0, 1'b1, 1'b1, rnd_frame());
        step(1'b1, 1'b1, 1'b0, rnd_frame());
        idle(10, 1'b1);

        // Five drops to exercise counter saturation
        step(1'b1, 1'b0, 1'b0, rnd_frame());
        step(1'b1, 1'b0, 1'b0, rnd_frame());
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, rnd_frame());
            idle(2, 1'b0);
        end
        idle(20, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 5) == 0, ($urandom % 4) != 0, ($urandom % 700) == 0, rnd_frame());
        end
        idle(20, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
